// File: rtl/pre_if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pre_if_stage_pkg
// Purpose  : Shared widths, reset address and state encodings for the pre-IF
//            (PI) stage of the in-order pipeline.
// Contents : PcWidth        - architectural PC width
//            PiToIfBusWidth - PI->IF bus width (33 with PREIF_ADEF_CHECK_EN,
//                             carrying the ADEF flag in bit 32; else 32)
//            RESET_PC_DEF   - default first fetch address
//            pi_state_e     - BOOT / RUN encodings
// Config   : PREIF_ADEF_CHECK_EN (optional instruction-address alignment check)
// Revision : 1.0 - initial release
// ============================================================================
package pre_if_stage_pkg;

  localparam int PcWidth = 32;

`ifdef PREIF_ADEF_CHECK_EN
  localparam int PiToIfBusWidth = 33;
`else
  localparam int PiToIfBusWidth = 32;
`endif

  localparam logic [PcWidth-1:0] RESET_PC_DEF = 32'h1c00_0000;

  typedef enum logic [0:0] {
    PI_BOOT = 1'b0,
    PI_RUN  = 1'b1
  } pi_state_e;

  // A fetch address is misaligned when either of its two low bits is set.
  function automatic logic pc_misaligned(input logic [PcWidth-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage : pre_if_stage_pkg
`default_nettype wire

// File: rtl/pre_if_stage_npc_sel.sv
`default_nettype none
// ============================================================================
// Module   : pre_if_stage_npc_sel
// Purpose  : Combinational next-PC priority mux for the pre-IF stage.
//            Priority: exception/ertn flush > branch redirect > sequential
//            advance on handshake > hold.
// Ports    : pc          in  current fetch PC
//            hs          in  PI->IF handshake this cycle
//            br_taken    in  branch redirect request
//            br_target   in  branch target
//            excp_flush  in  exception / ertn flush request
//            excp_entry  in  exception entry / era target
//            npc         out next value of the fetch PC
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module pre_if_stage_npc_sel
  import pre_if_stage_pkg::*;
#(
  parameter logic [PcWidth-1:0] PC_STEP = 32'd4
) (
  input  logic [PcWidth-1:0] pc,
  input  logic               hs,
  input  logic               br_taken,
  input  logic [PcWidth-1:0] br_target,
  input  logic               excp_flush,
  input  logic [PcWidth-1:0] excp_entry,
  output logic [PcWidth-1:0] npc
);

  // The add is carried out at PC width, so 0xFFFF_FFFC steps to 0.
  logic [PcWidth-1:0] w_seq_pc;
  assign w_seq_pc = pc + PC_STEP;

  always_comb begin
    npc = pc;
    if (excp_flush) begin
      npc = excp_entry;
    end else if (br_taken) begin
      // A branch arriving with a flush is dropped, never buffered.
      npc = br_target;
    end else if (hs) begin
      npc = w_seq_pc;
    end
  end

endmodule : pre_if_stage_npc_sel
`default_nettype wire

// File: rtl/pre_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : pre_if_stage
// Purpose  : Pre-IF stage. Owns the architectural fetch PC, presents it to IF
//            through a valid/allowin handshake and issues the synchronous
//            instruction-SRAM read for the PC being accepted.
// Ports    : clk              in  clock
//            rst              in  synchronous active-high reset
//            if_allowin_i     in  IF can accept a PC this cycle
//            pi_to_if_valid_o out PI holds a valid PC for IF
//            pi_to_if_obus    out fetch PC (bit 32 = ADEF when enabled)
//            br_taken_i       in  branch/jump redirect pulse
//            br_target_i      in  branch target
//            excp_flush_i     in  exception / ertn flush pulse
//            excp_entry_i     in  exception entry / era target
//            inst_sram_en_o   out instruction-SRAM read enable
//            inst_sram_addr_o out instruction-SRAM read address
// Config   : PREIF_ADEF_CHECK_EN - widen the bus with an ADEF flag and
//            suppress the SRAM read for misaligned PCs.
// Revision : 1.0 - initial release
// ============================================================================
module pre_if_stage
  import pre_if_stage_pkg::*;
#(
  parameter logic [PcWidth-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [PcWidth-1:0] PC_STEP  = 32'd4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_allowin_i,
  output logic                      pi_to_if_valid_o,
  output logic [PiToIfBusWidth-1:0] pi_to_if_obus,
  input  logic                      br_taken_i,
  input  logic [PcWidth-1:0]        br_target_i,
  input  logic                      excp_flush_i,
  input  logic [PcWidth-1:0]        excp_entry_i,
  output logic                      inst_sram_en_o,
  output logic [PcWidth-1:0]        inst_sram_addr_o
);

  pi_state_e          r_state;
  pi_state_e          w_state_nxt;
  logic [PcWidth-1:0] r_pc;
  logic [PcWidth-1:0] w_npc;
  logic               w_valid;
  logic               w_hs;

  // --------------------------------------------------------------------------
  // Boot sequencer: one idle cycle after reset, then valid for good.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PI_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    case (r_state)
      PI_BOOT: begin
        w_state_nxt = PI_RUN;
      end
      PI_RUN: begin
        w_valid     = 1'b1;
        w_state_nxt = PI_RUN;
      end
      default: begin
        w_state_nxt = PI_BOOT;
      end
    endcase
  end

  // Valid comes straight from the state register, so redirect inputs have
  // no combinational path to any output.
  assign w_hs = w_valid & if_allowin_i;

  // --------------------------------------------------------------------------
  // Fetch PC register. Redirects load it even when IF is not accepting; the
  // un-accepted wrong-path PC is simply overwritten.
  // --------------------------------------------------------------------------
  pre_if_stage_npc_sel #(
    .PC_STEP   (PC_STEP)
  ) u_npc_sel (
    .pc        (r_pc),
    .hs        (w_hs),
    .br_taken  (br_taken_i),
    .br_target (br_target_i),
    .excp_flush(excp_flush_i),
    .excp_entry(excp_entry_i),
    .npc       (w_npc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_npc;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. The SRAM is read on the handshake itself so that the instruction
  // data returns in the same cycle the PC is registered into IF.
  // --------------------------------------------------------------------------
  assign pi_to_if_valid_o = w_valid;
  assign inst_sram_addr_o = r_pc;

`ifdef PREIF_ADEF_CHECK_EN
  logic w_adef;
  assign w_adef         = pc_misaligned(r_pc);
  assign pi_to_if_obus  = {w_adef, r_pc};
  // The PC still advances on hs; only the memory read is suppressed.
  assign inst_sram_en_o = w_hs & ~w_adef;
`else
  assign pi_to_if_obus  = r_pc;
  assign inst_sram_en_o = w_hs;
`endif

endmodule : pre_if_stage
`default_nettype wire

// File: doc/pre_if_stage.md
Name: pre_if_stage

Overview:
- Pre-IF (PI) stage of the in-order pipeline. Owns the architectural fetch PC and issues the synchronous instruction-SRAM request.
- Drives the PC bus and valid into IF through the valid/allowin handshake that IF consumes.
- Applies branch redirects from ID/EXE and exception/ertn redirects from WB/CSR.

Parameters:
- RESET_PC, 32'h1c00_0000, first fetch address after reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- if_allowin_i  in  1  IF can accept a PC this cycle.
- pi_to_if_valid_o  out  1  PI holds a valid PC for IF.
- pi_to_if_obus  out  `PiToIfBusWidth  fetch PC to IF (32 bits; 33 with ADEF check).
- br_taken_i  in  1  branch/jump redirect request, one-cycle pulse.
- br_target_i  in  32  branch target.
- excp_flush_i  in  1  exception or ertn flush, one-cycle pulse.
- excp_entry_i  in  32  exception entry or era target.
- inst_sram_en_o  out  1  instruction-SRAM read enable.
- inst_sram_addr_o  out  32  instruction-SRAM read address.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: pc_reg=RESET_PC, state=BOOT, pi_to_if_valid_o=0, inst_sram_en_o=0.
- State machine:
  - BOOT: valid=0. Exactly one cycle after rst deasserts, go to RUN.
  - RUN: valid=1 continuously until the next rst.
- Outputs: pi_to_if_obus = pc_reg; inst_sram_addr_o = pc_reg.
- Handshake: hs = pi_to_if_valid_o & if_allowin_i.
  - inst_sram_en_o = hs, combinational, so the instruction data returns in the same cycle the PC is registered into IF.
- pc_reg update, in priority order:
  1. excp_flush_i: pc_reg <= excp_entry_i, regardless of hs.
  2. br_taken_i: pc_reg <= br_target_i, regardless of hs. An un-accepted wrong-path PC is dropped.
  3. hs: pc_reg <= pc_reg + PC_STEP, truncated to 32 bits; 0xFFFF_FFFC wraps to 0.
  4. Otherwise hold.
- Redirect timing:
  - A redirect in the same cycle as hs: the old PC is still accepted by IF, and the new target is presented the next cycle.
  - Squashing the IF-stage copy is not this block's job.
- Simultaneous flush and branch: flush wins; the branch is discarded and not buffered.
- Stall: while if_allowin_i=0, pc_reg and the outputs stay stable. A redirect still replaces pc_reg.
- Redirect during BOOT: pc_reg is updated. The first valid PC presented in RUN is the redirect target.
- rst asserted mid-operation: the next cycle is BOOT with pc_reg=RESET_PC. Any redirect on the same edge is ignored.
- No combinational path from br/excp inputs to any output.

Optional Feature:
- PREIF_ADEF_CHECK_EN defined:
  - `PiToIfBusWidth is 33; bit 32 = adef = (pc_reg[1:0] != 0).
  - inst_sram_en_o = hs & ~adef.
  - The PC still advances on hs, so the faulting PC propagates to IF with its flag.
- Undefined: the bus is 32 bits with no check, and the SRAM is enabled on every hs.

Decomposition:
- DefineModuleBus.h holds `PcWidth, `PiToIfBusWidth (conditional on the macro), `RESET_PC and the BOOT/RUN encodings.
- One natural sub-module: npc_sel, the combinational next-PC priority mux (flush/branch/sequential/hold). The state and pc_reg stay in pre_if_stage.

Test Plan:
1. Boot: assert rst 3 cycles, then release with if_allowin_i=1 → valid=0 in the first cycle after release. Next cycle valid=1, obus=0x1c000000, sram_en=1. Following cycles show 0x1c000004, 0x1c000008.
2. Stall: hold if_allowin_i=0 for 4 cycles at pc 0x1c000010 → obus stable, sram_en=0. Release → sram_en=1 with addr 0x1c000010, then 0x1c000014.
3. Branch during stall: pc 0x1c000020 with allowin=0, pulse br_taken_i, br_target_i=0x1c000100 → next cycle obus=0x1c000100; 0x1c000020 is never enabled to SRAM.
4. Flush+branch: same cycle excp_flush_i with entry 0x1c008000 and br_taken_i with target 0x1c000200 → next obus=0x1c008000.
5. Wrap: force pc 0xFFFFFFFC with hs → next obus=0x00000000.
6. With PREIF_ADEF_CHECK_EN: br_target_i=0x1c000102 → obus[32]=1, sram_en=0 on hs, next pc 0x1c000106.
